// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction / data) arbiter in front of a single
//               fixed-latency external memory. Data side has priority.
//               Optional macro ARB_STARVE_EN adds instruction-side
//               starvation avoidance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int WORD_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [WORD_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [WORD_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [WORD_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [WORD_WIDTH-1:0] d_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  generate
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 7)
    begin : g_bad_params
      $error("mem_arbiter: MEM_LATENCY must be 1..15 and STARVE_LIMIT 1..7");
    end
  endgenerate

  localparam logic [3:0] c_LAT_M1 = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic                  r_sel_d;
  logic                  r_we;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [WORD_WIDTH-1:0] r_mem_addr;
  logic [WORD_WIDTH-1:0] r_mem_wdata;
  logic                  r_i_ack;
  logic                  r_d_ack;
  logic [WORD_WIDTH-1:0] r_i_rdata;
  logic [WORD_WIDTH-1:0] r_d_rdata;
  logic                  w_force_i;
  logic                  w_grant_d;
  logic                  w_grant_i;

`ifdef ARB_STARVE_EN
  localparam logic [2:0] c_STARVE_MAX = 3'(STARVE_LIMIT);
  logic [2:0] r_starve;

  // Saturating count of arbitrations the instruction side lost while waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= 3'd0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_i) begin
        r_starve <= 3'd0;
      end else if (w_grant_d && i_req && (r_starve != c_STARVE_MAX)) begin
        r_starve <= r_starve + 3'd1;
      end
    end
  end

  assign w_force_i = (r_starve == c_STARVE_MAX);
`else
  assign w_force_i = 1'b0;
`endif

  assign w_grant_d = d_req & ~(w_force_i & i_req);
  assign w_grant_i = i_req & ~w_grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_req || d_req) w_state_next = S_ACCESS;
      S_ACCESS: if (r_cnt == 4'd0)  w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Memory strobes are launched at the grant edge and cleared at the edge
  // that samples mem_rdata, so they are high for exactly MEM_LATENCY cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_sel_d     <= 1'b0;
      r_we        <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d || w_grant_i) begin
            r_sel_d     <= w_grant_d;
            r_we        <= w_grant_d & d_we;
            r_cnt       <= c_LAT_M1;
            r_mem_addr  <= w_grant_d ? d_addr : i_addr;
            r_mem_wdata <= (w_grant_d && d_we) ? d_wdata : '0;
            r_mem_read  <= ~(w_grant_d & d_we);
            r_mem_write <= w_grant_d & d_we;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            if (r_sel_d) begin
              r_d_ack <= 1'b1;
              if (!r_we) r_d_rdata <= mem_rdata;
            end else begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
